wire_bit_encoder: RTL and testbench

//  Consumes the serializer's bit stream and drives the controller-bus one-wire line.

---
 rtl/wire_bit_encoder_pkg.sv | 28 ++
 rtl/wire_unit_timer.sv | 33 +++
 rtl/wire_bit_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_wire_bit_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wire_bit_encoder_pkg.sv
// Shared definitions for the one-wire bit encoder: FSM state types and
// pulse-width phase lengths (in timing units).
package wire_bit_encoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        LOW,
        HIGH,
        STOP,
        REL
    } enc_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT
    } fetch_state_t;

    localparam int ZERO_LOW_UNITS = 3;
    localparam int ONE_LOW_UNITS  = 1;
    localparam int BIT_UNITS      = 4;

    function automatic logic [1:0] low_units(input logic bit_val);
        return bit_val ? 2'(ONE_LOW_UNITS) : 2'(ZERO_LOW_UNITS);
    endfunction

endpackage

// File: rtl/wire_unit_timer.sv
// Prescaler plus 2-bit unit counter; unit_tick marks the last clk of each unit.
// clear has priority over count_en and restarts both counters from zero.
module wire_unit_timer #(
    parameter int UNIT_CYCLES = 25,
    parameter int UNIT_WIDTH  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       count_en,
    output logic       unit_tick,
    output logic [1:0] units
);

    logic [UNIT_WIDTH-1:0] presc;

    assign unit_tick = count_en && (presc == UNIT_WIDTH'(UNIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc <= '0;
            units <= '0;
        end else if (count_en) begin
            if (unit_tick) begin
                presc <= '0;
                units <= units + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wire_bit_encoder.sv
// Pulls bits from the serializer and emits pulse-width coded one-wire timing.
// Optional stop-bit low phase enabled by defining WIRE_ENC_STOP_BIT_EN.
module wire_bit_encoder #(
    parameter int UNIT_CYCLES    = 25,
    parameter int UNIT_WIDTH     = 5,
    parameter int STOP_LOW_UNITS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic ser_ready,
    input  logic ser_strobe,
    input  logic ser_data,
    input  logic ser_empty,
    output logic line_oe,
    output logic busy,
    output logic done
);

    import wire_bit_encoder_pkg::*;

`ifdef WIRE_ENC_STOP_BIT_EN
    localparam enc_state_t END_STATE = STOP;
    localparam logic       END_OE    = 1'b1;
`else
    localparam enc_state_t END_STATE = REL;
    localparam logic       END_OE    = 1'b0;
`endif

    enc_state_t   state;
    fetch_state_t fstate;

    logic       cur_bit;
    logic       next_bit;
    logic       next_valid;
    logic       next_end;
    logic       high_over;
    logic       unit_tick;
    logic [1:0] units;
    logic [1:0] low_last;
    logic [1:0] high_last;
    logic       low_end;
    logic       high_end;
    logic       stop_end;
    logic       rel_end;
    logic       resolved;
    logic       fetch_go;
    logic       consume;
    logic       phase_change;
    logic       timer_clear;
    logic       timer_en;

    // Phase indices are last-unit numbers: a phase of N units ends on unit N-1.
    assign low_last  = low_units(cur_bit) - 2'd1;
    assign high_last = 2'(BIT_UNITS - 1) - low_units(cur_bit);

    assign low_end   = unit_tick && (units == low_last);
    assign high_end  = high_over || (unit_tick && (units == high_last));
    assign stop_end  = unit_tick && (units == 2'(STOP_LOW_UNITS - 1));
    assign rel_end   = unit_tick && (units == 2'd0);
    assign resolved  = next_valid || next_end;

    assign fetch_go  = ((state == IDLE) && start) || ((state == LOW) && low_end);
    assign consume   = ((state == PRIME) || ((state == HIGH) && high_end)) && resolved;

    always_comb begin
        phase_change = 1'b0;
        case (state)
            LOW:     phase_change = low_end;
            HIGH:    phase_change = high_end && resolved;
            STOP:    phase_change = stop_end;
            REL:     phase_change = rel_end;
            default: phase_change = 1'b0;
        endcase
    end

    assign timer_en    = (state != IDLE) && (state != PRIME);
    assign timer_clear = !timer_en || phase_change;

    wire_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .UNIT_WIDTH (UNIT_WIDTH)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count_en (timer_en),
        .unit_tick(unit_tick),
        .units    (units)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fstate     <= F_IDLE;
            ser_ready  <= 1'b0;
            next_bit   <= 1'b0;
            next_valid <= 1'b0;
            next_end   <= 1'b0;
        end else begin
            ser_ready <= 1'b0;
            if (consume) begin
                next_valid <= 1'b0;
                next_end   <= 1'b0;
            end
            case (fstate)
                F_IDLE: begin
                    if (fetch_go) begin
                        fstate    <= F_REQ;
                        ser_ready <= 1'b1;
                    end
                end
                F_REQ: fstate <= F_WAIT;
                F_WAIT: begin
                    if (ser_strobe) begin
                        next_bit   <= ser_data;
                        next_valid <= 1'b1;
                        fstate     <= F_IDLE;
                    end else if (ser_empty) begin
                        next_end <= 1'b1;
                        fstate   <= F_IDLE;
                    end else begin
                        // Serializer reloading: ask again.
                        fstate    <= F_REQ;
                        ser_ready <= 1'b1;
                    end
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line_oe   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_bit   <= 1'b0;
            high_over <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    if (next_valid) begin
                        cur_bit <= next_bit;
                        line_oe <= 1'b1;
                        state   <= LOW;
                    end else if (next_end) begin
                        line_oe <= END_OE;
                        state   <= END_STATE;
                    end
                end
                LOW: begin
                    if (low_end) begin
                        line_oe   <= 1'b0;
                        high_over <= 1'b0;
                        state     <= HIGH;
                    end
                end
                HIGH: begin
                    // Once the nominal phase has elapsed, wait cycle-by-cycle for the fetch.
                    if (high_end) begin
                        if (next_valid) begin
                            cur_bit <= next_bit;
                            line_oe <= 1'b1;
                            state   <= LOW;
                        end else if (next_end) begin
                            line_oe <= END_OE;
                            state   <= END_STATE;
                        end else begin
                            high_over <= 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        line_oe <= 1'b0;
                        state   <= REL;
                    end
                end
                REL: begin
                    if (rel_end) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    line_oe <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wire_bit_encoder.sv
// Scoreboard bench for wire_bit_encoder: expected line segments are queued from
// the bits handed to the serializer model and compared as the line is observed.
module tb_wire_bit_encoder;

    localparam int UC       = 4;
    localparam int STOP_LOW = 2;
    localparam int BUDGET   = 600;
`ifdef WIRE_ENC_STOP_BIT_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, ser_strobe, ser_data, ser_empty;
    logic ser_ready, line_oe, busy, done;

    always #5 clk = ~clk;

    wire_bit_encoder #(
        .UNIT_CYCLES   (UC),
        .UNIT_WIDTH    (3),
        .STOP_LOW_UNITS(STOP_LOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ser_ready (ser_ready),
        .ser_strobe(ser_strobe),
        .ser_data  (ser_data),
        .ser_empty (ser_empty),
        .line_oe   (line_oe),
        .busy      (busy),
        .done      (done)
    );

    int checks   = 0;
    int failures = 0;

    bit ser_q[$];
    int exp_q[$];
    int obs_q[$];
    int reload_cnt = 0;
    bit pend       = 1'b0;
    bit mon_active = 1'b0;
    int run_lvl    = 0;
    int run_len    = 0;
    bit done_seen  = 1'b0;
    int ready_cnt  = 0;
    int strobe_cnt = 0;

    // One clock: observe at negedge, then serializer model answers after posedge.
    task automatic cycle();
        @(negedge clk);
        if (ser_ready) ready_cnt++;
        if (ser_strobe) strobe_cnt++;
        if (done) done_seen = 1'b1;
        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (line_oe) begin
                mon_active = 1'b1;
                run_lvl    = 1;
                run_len    = 1;
            end
        end else if (done) begin
            obs_q.push_back(run_lvl * 10000 + run_len);
            mon_active = 1'b0;
        end else if (int'(line_oe) != run_lvl) begin
            obs_q.push_back(run_lvl * 10000 + run_len);
            run_lvl = int'(line_oe);
            run_len = 1;
        end else begin
            run_len++;
        end
        pend = ser_ready;
        @(posedge clk);
        #1;
        ser_strobe = 1'b0;
        if (pend && ser_q.size() > 0) begin
            if (reload_cnt > 0) begin
                reload_cnt--;
            end else begin
                ser_strobe = 1'b1;
                ser_data   = ser_q.pop_front();
            end
        end
        ser_empty = (ser_q.size() == 0);
    endtask

    task automatic load_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) ser_q.push_back(b[i]);
    endtask

    // Encoded segment = level*10000 + length in cycles.
    task automatic build_expected();
        int n;
        int lo;
        int hi;
        n = ser_q.size();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < n; i++) begin
            lo = ser_q[i] ? 1 * UC : 3 * UC;
            hi = 4 * UC - lo;
            if (i == n - 1 && !STOP_EN) hi += UC;
            exp_q.push_back(10000 + lo);
            exp_q.push_back(hi);
        end
        if (STOP_EN) begin
            exp_q.push_back(10000 + STOP_LOW * UC);
            exp_q.push_back(UC);
        end
    endtask

    task automatic run_frame(input int restart_at, output bit ok);
        done_seen = 1'b0;
        ok        = 1'b0;
        start     = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (done_seen) begin
                ok = 1'b1;
                break;
            end
            start = (i == restart_at);
            cycle();
        end
        start = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        ser_strobe = 1'b0;
        ser_data   = 1'b0;
        ser_empty  = 1'b1;
        repeat (3) cycle();
        checks++; if (line_oe !== 1'b0) begin failures++; $display("FAIL reset_line_oe got=%b expected=0", line_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b expected=0", done); end
        checks++; if (ser_ready !== 1'b0) begin failures++; $display("FAIL reset_ser_ready got=%b expected=0", ser_ready); end
        reset = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic test_single_byte();
        bit ok;
        int r0, s0, e, o;
        r0 = ready_cnt;
        s0 = strobe_cnt;
        load_byte(8'h80);
        build_expected();
        run_frame(-1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL byte80_done got=%b expected=1", ok); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL byte80_segcount got=%0d expected=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL byte80_seg[%0d] got=%0d expected=%0d", k, o, e); end
        end
        checks++; if (strobe_cnt - s0 !== 8) begin failures++; $display("FAIL byte80_strobes got=%0d expected=8", strobe_cnt - s0); end
        checks++; if (ready_cnt - r0 !== 9) begin failures++; $display("FAIL byte80_ready got=%0d expected=9", ready_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s0, e, o;
        s0 = strobe_cnt;
        load_byte(8'hA5);
        load_byte(8'h3C);
        build_expected();
        run_frame(40, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b expected=1", ok); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_segcount got=%0d expected=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_seg[%0d] got=%0d expected=%0d", k, o, e); end
        end
        checks++; if (strobe_cnt - s0 !== 16) begin failures++; $display("FAIL b2b_strobes got=%0d expected=16", strobe_cnt - s0); end
    endtask

    task automatic test_empty_frame();
        bit ok;
        int r0, s0, e, o;
        r0 = ready_cnt;
        s0 = strobe_cnt;
        build_expected();
        run_frame(-1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL empty_done got=%b expected=1", ok); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL empty_segcount got=%0d expected=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL empty_seg[%0d] got=%0d expected=%0d", k, o, e); end
        end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL empty_strobes got=%0d expected=0", strobe_cnt - s0); end
        checks++; if (ready_cnt - r0 !== 1) begin failures++; $display("FAIL empty_ready got=%0d expected=1", ready_cnt - r0); end
    endtask

    task automatic test_retry();
        bit ok;
        int r0, e, o;
        r0 = ready_cnt;
        load_byte(8'h96);
        build_expected();
        reload_cnt = 1;
        run_frame(-1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL retry_done got=%b expected=1", ok); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL retry_segcount got=%0d expected=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL retry_seg[%0d] got=%0d expected=%0d", k, o, e); end
        end
        checks++; if (ready_cnt - r0 !== 10) begin failures++; $display("FAIL retry_ready got=%0d expected=10", ready_cnt - r0); end
    endtask

    task automatic test_reset_mid_low();
        bit ok;
        int e, o;
        load_byte(8'h00);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 50 && line_oe !== 1'b1; i++) cycle();
        checks++; if (line_oe !== 1'b1) begin failures++; $display("FAIL midlow_reach got=%b expected=1", line_oe); end
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        checks++; if (line_oe !== 1'b0) begin failures++; $display("FAIL midlow_line_oe got=%b expected=0", line_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midlow_busy got=%b expected=0", busy); end
        reset = 1'b0;
        ser_q.delete();
        reload_cnt = 0;
        ser_strobe = 1'b0;
        ser_empty  = 1'b1;
        repeat (2) cycle();
        load_byte(8'h5A);
        build_expected();
        run_frame(-1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL postreset_done got=%b expected=1", ok); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL postreset_segcount got=%0d expected=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL postreset_seg[%0d] got=%0d expected=%0d", k, o, e); end
        end
    endtask

    task automatic test_all_ones();
        bit ok;
        int e, o;
        load_byte(8'hFF);
        build_expected();
        run_frame(-1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ones_done got=%b expected=1", ok); end
        checks++; if (obs_q.size() !== exp_q.size()) begin failures++; $display("FAIL ones_segcount got=%0d expected=%0d", obs_q.size(), exp_q.size()); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL ones_seg[%0d] got=%0d expected=%0d", k, o, e); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ones_busy_after got=%b expected=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_empty_frame();
        test_retry();
        test_reset_mid_low();
        test_all_ones();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
